// File: rtl/fpadd_result_commit_pkg.sv
// Shared FP adder constants: result-type encodings, special-value bit patterns,
// fflags bit positions, rounding-mode encoding and the stage-1 capture record.
package fpadd_result_commit_pkg;

  localparam logic [3:0] ZT_NORMAL = 4'b0000;
  localparam logic [3:0] ZT_QNAN   = 4'b0001;
  localparam logic [3:0] ZT_NINF   = 4'b0010;
  localparam logic [3:0] ZT_PINF   = 4'b0011;
  localparam logic [3:0] ZT_PZERO  = 4'b0100;
  localparam logic [3:0] ZT_XZERO  = 4'b0101;
  localparam logic [3:0] ZT_NZERO0 = 4'b0110;
  localparam logic [3:0] ZT_NZERO1 = 4'b0111;
  localparam int         ZT_CVT_BIT = 3;

  localparam logic [63:0] FP_CANON_NAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] FP_NINF      = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] FP_PINF      = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] FP_PZERO     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] FP_NZERO     = 64'h8000_0000_0000_0000;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  localparam logic [2:0] FRM_RDN = 3'b010;

  typedef struct packed {
    logic [3:0]  ztype;
    logic        invalid;
    logic        denorm;
    logic [63:0] raw_result;
    logic [2:0]  raw_flags;
    logic [2:0]  frm;
  } s1_t;

endpackage

// File: rtl/fpadd_result_commit_fflags_acc.sv
// Sticky 5-bit fflags register: CSR write replaces the value, retiring op flags OR in.
// Write and accumulate in the same cycle combine as wdata | acc_flags.
module fpadd_result_commit_fflags_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [4:0] wdata,
  input  logic       acc_en,
  input  logic [4:0] acc_flags,
  output logic [4:0] flags
);

  logic [4:0] base;

  always_comb begin
    base = we ? wdata : flags;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else begin
      flags <= base | (acc_en ? acc_flags : 5'b0);
    end
  end

endmodule

// File: rtl/fpadd_result_commit.sv
// Retires FP adder results through a 2-stage valid/stall/flush pipeline, substituting
// special values by result type, accumulating sticky fflags and counting denormal operands.
module fpadd_result_commit
  import fpadd_result_commit_pkg::*;
#(
  parameter int          DCNT_W    = 16,
  parameter logic [63:0] CANON_NAN = FP_CANON_NAN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InValid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [3:0]        Ztype,
  input  logic              Invalid,
  input  logic              Denorm,
  input  logic [63:0]       RawResult,
  input  logic [2:0]        RawFlags,
  input  logic [2:0]        Frm,
  output logic [63:0]       ResultW,
  output logic              ResultValid,
  output logic [4:0]        FFlags,
  input  logic              FFlagsWe,
  input  logic [4:0]        FFlagsWData,
  output logic [DCNT_W-1:0] DenormCount,
  input  logic              DenormClr
);

  localparam logic [DCNT_W-1:0] DCNT_MAX = '1;

  s1_t         s1_q;
  logic        s1_vld;
  logic        s2_vld;
  logic [4:0]  s2_flags;
  logic        s2_denorm;
  logic [63:0] sub_result;
  logic [4:0]  sub_flags;
  logic        retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
    end else if (Flush) begin
      s1_vld <= 1'b0;
    end else if (!Stall) begin
      s1_vld <= InValid;
    end
  end

  // Stage-1 payload carries no reset; only the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (!Stall && InValid) begin
      s1_q <= '{ztype: Ztype, invalid: Invalid, denorm: Denorm,
                raw_result: RawResult, raw_flags: RawFlags, frm: Frm};
    end
  end

  always_comb begin
    sub_result           = s1_q.raw_result;
    sub_flags            = '0;
    sub_flags[FFLAG_NV]  = s1_q.invalid;
    sub_flags[FFLAG_DZ]  = 1'b0;
    sub_flags[FFLAG_OF]  = s1_q.raw_flags[2];
    sub_flags[FFLAG_UF]  = s1_q.raw_flags[1];
    sub_flags[FFLAG_NX]  = s1_q.raw_flags[0];
    if (s1_q.ztype[ZT_CVT_BIT]) begin
      sub_flags[FFLAG_NV] = 1'b0;
    end else if (s1_q.ztype != ZT_NORMAL) begin
      sub_flags[FFLAG_OF] = 1'b0;
      sub_flags[FFLAG_UF] = 1'b0;
      sub_flags[FFLAG_NX] = 1'b0;
      case (s1_q.ztype)
        ZT_QNAN:   sub_result = CANON_NAN;
        ZT_NINF:   sub_result = FP_NINF;
        ZT_PINF:   sub_result = FP_PINF;
        ZT_PZERO:  sub_result = FP_PZERO;
        ZT_XZERO:  sub_result = (s1_q.frm == FRM_RDN) ? FP_NZERO : FP_PZERO;
        ZT_NZERO0,
        ZT_NZERO1: sub_result = FP_NZERO;
        default:   sub_result = s1_q.raw_result;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld    <= 1'b0;
      ResultW   <= '0;
      s2_flags  <= '0;
      s2_denorm <= 1'b0;
    end else begin
      if (Flush) begin
        s2_vld <= 1'b0;
      end else if (!Stall) begin
        s2_vld <= s1_vld;
      end
      if (!Stall) begin
        ResultW   <= sub_result;
        s2_flags  <= sub_flags;
        s2_denorm <= s1_q.denorm;
      end
    end
  end

  assign ResultValid = s2_vld;
  assign retire      = s2_vld & ~Stall & ~Flush;

  always_ff @(posedge clk) begin
    if (reset || DenormClr) begin
      DenormCount <= '0;
    end else if (retire && s2_denorm && DenormCount != DCNT_MAX) begin
      DenormCount <= DenormCount + 1'b1;
    end
  end

  fpadd_result_commit_fflags_acc u_fflags_acc (
    .clk       (clk),
    .reset     (reset),
    .we        (FFlagsWe),
    .wdata     (FFlagsWData),
    .acc_en    (retire),
    .acc_flags (s2_flags),
    .flags     (FFlags)
  );

endmodule

// File: tb/tb_fpadd_result_commit.sv
// Directed bench for fpadd_result_commit with a 2-bit denormal counter.
module tb_fpadd_result_commit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        InValid = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [3:0]  Ztype = '0;
  logic        Invalid = 1'b0;
  logic        Denorm = 1'b0;
  logic [63:0] RawResult = '0;
  logic [2:0]  RawFlags = '0;
  logic [2:0]  Frm = '0;
  logic [63:0] ResultW;
  logic        ResultValid;
  logic [4:0]  FFlags;
  logic        FFlagsWe = 1'b0;
  logic [4:0]  FFlagsWData = '0;
  logic [1:0]  DenormCount;
  logic        DenormClr = 1'b0;

  int checks = 0;
  int failures = 0;

  fpadd_result_commit #(.DCNT_W(2)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .Stall(Stall), .Flush(Flush),
    .Ztype(Ztype), .Invalid(Invalid), .Denorm(Denorm), .RawResult(RawResult),
    .RawFlags(RawFlags), .Frm(Frm), .ResultW(ResultW), .ResultValid(ResultValid),
    .FFlags(FFlags), .FFlagsWe(FFlagsWe), .FFlagsWData(FFlagsWData),
    .DenormCount(DenormCount), .DenormClr(DenormClr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single edge; stage1 holds it afterwards.
  task automatic drive(input logic [3:0] z, input logic inv, input logic den,
                       input logic [63:0] raw, input logic [2:0] rf, input logic [2:0] frm);
    InValid = 1'b1; Ztype = z; Invalid = inv; Denorm = den;
    RawResult = raw; RawFlags = rf; Frm = frm;
    tick();
    InValid = 1'b0;
  endtask

  // Runs an op to stage2, checks the substituted result, then lets it retire.
  task automatic run_op(input string tag, input logic [3:0] z, input logic inv,
                        input logic [63:0] raw, input logic [2:0] rf, input logic [2:0] frm,
                        input logic [63:0] exp_res);
    drive(z, inv, 1'b0, raw, rf, frm);
    tick();
    chk({tag, "_vld"}, 64'(ResultValid), 64'd1);
    chk({tag, "_res"}, ResultW, exp_res);
    tick();
  endtask

  task automatic clear_flags();
    FFlagsWe = 1'b1; FFlagsWData = 5'b0;
    tick();
    FFlagsWe = 1'b0;
  endtask

  logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  initial begin
    tick(); tick();
    chk("rst_vld", 64'(ResultValid), 64'd0);
    chk("rst_res", ResultW, 64'd0);
    chk("rst_ff", 64'(FFlags), 64'd0);
    chk("rst_cnt", 64'(DenormCount), 64'd0);
    reset = 1'b0;
    tick();

    run_op("pinf", 4'b0011, 1'b0, 64'h1234_5678_9ABC_DEF0, 3'b111, 3'b000, 64'h7FF0_0000_0000_0000);
    chk("pinf_ff", 64'(FFlags), 64'd0);
    chk("pinf_vld_drop", 64'(ResultValid), 64'd0);

    run_op("qnan", 4'b0001, 1'b1, 64'h0, 3'b000, 3'b000, 64'h7FF8_0000_0000_0000);
    chk("qnan_ff", 64'(FFlags), 64'b10000);
    run_op("norm", 4'b0000, 1'b0, 64'h3FF0_0000_0000_0000, 3'b000, 3'b000, 64'h3FF0_0000_0000_0000);
    chk("sticky_nv", 64'(FFlags), 64'b10000);

    run_op("xz_rdn", 4'b0101, 1'b0, 64'h5, 3'b000, 3'b010, 64'h8000_0000_0000_0000);
    run_op("xz_rne", 4'b0101, 1'b0, 64'h5, 3'b000, 3'b000, 64'h0);
    run_op("nzero", 4'b0110, 1'b0, 64'h5, 3'b111, 3'b000, 64'h8000_0000_0000_0000);
    run_op("pzero", 4'b0100, 1'b0, 64'h5, 3'b000, 3'b010, 64'h0);
    run_op("ninf", 4'b0010, 1'b0, 64'h5, 3'b101, 3'b000, 64'hFFF0_0000_0000_0000);
    chk("special_ff", 64'(FFlags), 64'b10000);
    run_op("cvt", 4'b1011, 1'b0, 64'h4000_0000_0000_0001, 3'b001, 3'b000, 64'h4000_0000_0000_0001);
    chk("cvt_ff", 64'(FFlags), 64'b10001);

    clear_flags();
    chk("csr_clear", 64'(FFlags), 64'd0);

    // Stall while valid in stage2: result holds, no retire until released.
    drive(4'b0001, 1'b1, 1'b0, 64'h0, 3'b000, 3'b000);
    tick();
    Stall = 1'b1;
    tick(); tick();
    chk("s2stall_vld", 64'(ResultValid), 64'd1);
    chk("s2stall_ff", 64'(FFlags), 64'd0);
    Stall = 1'b0;
    tick();
    chk("s2stall_ret", 64'(FFlags), 64'b10000);
    chk("s2stall_drop", 64'(ResultValid), 64'd0);
    clear_flags();

    // Stall three cycles then flush while still stalled.
    drive(4'b0001, 1'b1, 1'b0, 64'h0, 3'b000, 3'b000);
    Stall = 1'b1;
    tick(); tick(); tick();
    chk("stall_vld", 64'(ResultValid), 64'd0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0; Stall = 1'b0;
    tick();
    chk("flush_vld1", 64'(ResultValid), 64'd0);
    tick();
    chk("flush_vld2", 64'(ResultValid), 64'd0);
    chk("flush_ff", 64'(FFlags), 64'd0);

    // CSR write coincides with a retiring NX op.
    drive(4'b0000, 1'b0, 1'b0, 64'h3FF0_0000_0000_0001, 3'b001, 3'b000);
    tick();
    FFlagsWe = 1'b1; FFlagsWData = 5'b01000;
    tick();
    FFlagsWe = 1'b0;
    chk("we_and_retire", 64'(FFlags), 64'b01001);

    chk("cnt_start", 64'(DenormCount), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b0, 1'b1, 64'h0000_0000_0000_0001, 3'b000, 3'b000);
      tick(); tick();
      chk($sformatf("cnt_%0d", i), 64'(DenormCount), 64'(exp_cnt[i]));
    end
    drive(4'b0000, 1'b0, 1'b1, 64'h0000_0000_0000_0001, 3'b000, 3'b000);
    tick();
    DenormClr = 1'b1;
    tick();
    DenormClr = 1'b0;
    chk("cnt_clr", 64'(DenormCount), 64'd0);
    chk("final_ff", 64'(FFlags), 64'b01001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
